// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: LSB-first through one full-adder cell, one bit per clock.
// Optional subtract mode enabled by defining SERIAL_ADDER_SUB_EN (adds the sub port).
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic             r_c;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;

    logic             w_accept;
    logic             w_last;
    logic             w_s;
    logic             w_cnext;
    logic [WIDTH-1:0] w_res_next;
    logic [WIDTH-1:0] w_b_load;
    logic             w_c_load;

    // A new request is only honoured when no operation is in flight.
    assign w_accept   = start && (r_state != S_RUN);
    assign w_last     = (r_state == S_RUN) && (r_cnt == CW'(WIDTH - 1));
    assign w_s        = r_a[0] ^ r_b[0] ^ r_c;
    assign w_cnext    = (r_a[0] & r_b[0]) | (r_a[0] & r_c) | (r_b[0] & r_c);
    assign w_res_next = {w_s, r_res[WIDTH-1:1]};

`ifdef SERIAL_ADDER_SUB_EN
    // Subtraction is A + ~B + 1; cin is not used in that mode.
    assign w_b_load = sub ? ~b : b;
    assign w_c_load = sub ? 1'b1 : cin;
`else
    assign w_b_load = b;
    assign w_c_load = cin;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_next = S_RUN;
            S_RUN:   if (w_last) w_state_next = S_DONE;
            S_DONE:  w_state_next = start ? S_RUN : S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (r_state)
            S_RUN:   busy = 1'b1;
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a    <= '0;
            r_b    <= '0;
            r_res  <= '0;
            r_c    <= 1'b0;
            r_cnt  <= '0;
            r_sum  <= '0;
            r_cout <= 1'b0;
            r_ovf  <= 1'b0;
        end else if (w_accept) begin
            r_a   <= a;
            r_b   <= w_b_load;
            r_c   <= w_c_load;
            r_res <= '0;
            r_cnt <= '0;
        end else if (r_state == S_RUN) begin
            r_a   <= r_a >> 1;
            r_b   <= r_b >> 1;
            r_res <= w_res_next;
            r_c   <= w_cnext;
            r_cnt <= r_cnt + 1'b1;
            // r_c still holds the carry into the MSB on the final bit.
            if (w_last) begin
                r_sum  <= w_res_next;
                r_cout <= w_cnext;
                r_ovf  <= r_c ^ w_cnext;
            end
        end
    end

    assign sum  = r_sum;
    assign cout = r_cout;
    assign ovf  = r_ovf;

endmodule
